mi_nios_cpu_nios2_oci_fifo_wr_ctrl: RTL and testbench
=====================================================

# mi_nios_cpu_nios2_oci_fifo_wr_ctrl

Write/read sequencer for the OCI trace FIFO. Accepts 0–3 trace words per cycle from the trace packer, admits as many as free space allows, and allocates consecutive write slots in the multi-port trace RAM. It advances the read pointer on consumer pops and maintains the occupancy count, free-space flags and a sticky overflow indication. It sits between the trace packer and the trace RAM/JTAG drain.

## Interface
- DEPTH_LOG2, default 4; FIFO depth = 2^DEPTH_LOG2 (16) words; minimum 2.
- clk, in, 1, sole clock; all state on rising edge.
- reset, in, 1, synchronous, active-high.
- input_tm_cnt, in, 2, number of trace words presented this cycle (0–3), slots 0..n-1 valid.
- rd_ready, in, 1, consumer accepts the word at fifo_rdptr this cycle.
- ovf_clr, in, 1, clears sticky overflow (and drop counter when configured).
- fifo_wrptr, out, DEPTH_LOG2, address of write slot 0; slot i writes to fifo_wrptr+i mod depth.
- fifo_wr0 / fifo_wr1 / fifo_wr2, out, 1 each, write enables for slots 0..2 (combinational).
- fifo_rdptr, out, DEPTH_LOG2, address of the oldest word.
- rd_valid, out, 1, FIFO non-empty (= ~empty).
- fifo_cnt, out, DEPTH_LOG2+1, registered occupancy 0..depth.
- empty, ge2_free, ge3_free, out, 1 each, decoded from registered fifo_cnt.
- overflow, out, 1, sticky; a word was dropped since the last clear.
- drop_cnt, out, 16, dropped-word counter (present only with the macro; see Configuration).

## Operation
- free = depth − fifo_cnt; empty = (fifo_cnt==0); ge2_free = free≥2; ge3_free = free≥3.
- pop = rd_valid & rd_ready.
- n_wr = min(input_tm_cnt, free). Free space is evaluated before the same-cycle pop; a popped slot is not reusable in the cycle it frees.
- fifo_wr0 = n_wr≥1; fifo_wr1 = n_wr≥2; fifo_wr2 = n_wr==3. Words are admitted in order; dropped words are always the highest-numbered slots.
- dropped = input_tm_cnt − n_wr (0..3).
- Next state:
  - fifo_cnt += n_wr − pop (width DEPTH_LOG2+1, never exceeds depth or underflows).
  - fifo_wrptr += n_wr mod depth.
  - fifo_rdptr += pop mod depth.
- Overflow is set when dropped≠0 and cleared by ovf_clr. Set wins over clear in the same cycle.
- No state machine; the block is a pointer/count datapath. Behaviour is identical for every fill level, including wrap-around of both pointers.

## Timing
- Reset values: fifo_cnt=0, fifo_wrptr=0, fifo_rdptr=0, overflow=0, drop_cnt=0. Consequently empty=1, rd_valid=0, ge2_free=1, ge3_free=1 (DEPTH_LOG2≥2).
- Reset asserted mid-operation discards all contents next edge; any writes or pops presented in the reset cycle are ignored for state. Write enables remain combinational but storage contents are don't-care.
- Write enables and addresses have zero latency, combinational from input_tm_cnt and registered fifo_cnt. No combinational path from rd_ready to the write enables.
- A written word is visible at rd_valid/fifo_rdptr one cycle after its write (no empty bypass).
- Full FIFO with a pop: the pop occurs, all input is dropped that cycle, and space becomes visible next cycle.

## Configuration
- MI_NIOS_OCI_FIFO_DROP_CNT_EN defined: drop_cnt port and register exist. drop_cnt += dropped each cycle, saturating at 0xFFFF. It is cleared by ovf_clr; if ovf_clr and a drop coincide, drop_cnt = dropped.
- Undefined: the drop_cnt port and register are absent; overflow behaviour is unchanged.

## Structure
- Shared package mi_nios_cpu_nios2_oci_pkg holds the constants TRACE_SLOTS=3 and DROP_CNT_W=16, and the typedef for the slot-count type (2-bit).
- One sub-module: mi_nios_cpu_nios2_oci_fifo_admit. It is combinational and maps (input_tm_cnt, fifo_cnt) to (n_wr, dropped, wr enables). Pointer and count registers stay in the top module.

## Test plan
- Reset, then input_tm_cnt=3 for 5 cycles with rd_ready=0: fifo_cnt goes 3,6,9,12,15; the 6th cycle of 3 writes only slot 0 (cnt=16), overflow=1, drop_cnt=2.
- FIFO full (cnt=16), input_tm_cnt=2, rd_ready=1: no write enables, cnt=15 next cycle, overflow set, drop_cnt +=2.
- cnt=14, fifo_wrptr=15, input_tm_cnt=3: wr0/wr1 at addresses 15 and 0, slot 2 dropped, fifo_wrptr=1 next cycle.
- Empty FIFO, input_tm_cnt=1 with rd_ready=1: rd_valid=0 that cycle; rd_valid=1 next cycle; pop then returns cnt to 0 and empty=1.
- overflow=1 and ovf_clr=1 with a concurrent drop: overflow stays 1. ovf_clr without a drop: overflow=0 and drop_cnt=0.
- Assert reset with cnt=9 and mixed traffic: next cycle all pointers and the count are 0, empty=1, overflow=0.

Source files
------------

// File: rtl/mi_nios_cpu_nios2_oci_pkg.sv
// ============================================================================
// mi_nios_cpu_nios2_oci_pkg : shared constants and types for the OCI trace FIFO
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mi_nios_cpu_nios2_oci_pkg;

  localparam int TRACE_SLOTS = 3;
  localparam int DROP_CNT_W  = 16;

  typedef logic [1:0] slot_cnt_t;

endpackage

`default_nettype wire

// File: rtl/mi_nios_cpu_nios2_oci_fifo_admit.sv
// ============================================================================
// mi_nios_cpu_nios2_oci_fifo_admit : maps offered word count and occupancy to
// admitted/dropped counts and per-slot write enables (combinational).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mi_nios_cpu_nios2_oci_fifo_admit
  import mi_nios_cpu_nios2_oci_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  slot_cnt_t             input_tm_cnt,
  input  logic [DEPTH_LOG2:0]   fifo_cnt,
  output slot_cnt_t             n_wr,
  output slot_cnt_t             dropped,
  output logic                  fifo_wr0,
  output logic                  fifo_wr1,
  output logic                  fifo_wr2
);

  localparam int             CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]  DEPTH = CW'(1) << DEPTH_LOG2;

  logic [CW-1:0] free;
  slot_cnt_t     room;

  always_comb begin
    free = DEPTH - fifo_cnt;
    // Room is capped at the slot count so the min() stays 2 bits wide
    room = (free >= CW'(TRACE_SLOTS)) ? slot_cnt_t'(TRACE_SLOTS) : free[1:0];
    n_wr     = (input_tm_cnt < room) ? input_tm_cnt : room;
    dropped  = input_tm_cnt - n_wr;
    fifo_wr0 = (n_wr != 2'd0);
    fifo_wr1 = (n_wr >= 2'd2);
    fifo_wr2 = (n_wr == 2'd3);
  end

endmodule

`default_nettype wire

// File: rtl/mi_nios_cpu_nios2_oci_fifo_wr_ctrl.sv
// ============================================================================
// mi_nios_cpu_nios2_oci_fifo_wr_ctrl : OCI trace FIFO pointer/count sequencer.
// Optional drop counter enabled by MI_NIOS_OCI_FIFO_DROP_CNT_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mi_nios_cpu_nios2_oci_fifo_wr_ctrl
  import mi_nios_cpu_nios2_oci_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             input_tm_cnt,
  input  logic                   rd_ready,
  input  logic                   ovf_clr,
  output logic [DEPTH_LOG2-1:0]  fifo_wrptr,
  output logic                   fifo_wr0,
  output logic                   fifo_wr1,
  output logic                   fifo_wr2,
  output logic [DEPTH_LOG2-1:0]  fifo_rdptr,
  output logic                   rd_valid,
  output logic [DEPTH_LOG2:0]    fifo_cnt,
  output logic                   empty,
  output logic                   ge2_free,
  output logic                   ge3_free,
  output logic                   overflow
`ifdef MI_NIOS_OCI_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]  drop_cnt
`endif
);

  localparam int             CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]  DEPTH = CW'(1) << DEPTH_LOG2;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]  wrptr_q, wrptr_d;
  logic [DEPTH_LOG2-1:0]  rdptr_q, rdptr_d;
  logic                   overflow_q, overflow_d;
  logic [CW-1:0]          free;
  logic                   pop;
  slot_cnt_t              n_wr;
  slot_cnt_t              dropped;

  mi_nios_cpu_nios2_oci_fifo_admit #(
    .DEPTH_LOG2   (DEPTH_LOG2)
  ) u_admit (
    .input_tm_cnt (input_tm_cnt),
    .fifo_cnt     (cnt_q),
    .n_wr         (n_wr),
    .dropped      (dropped),
    .fifo_wr0     (fifo_wr0),
    .fifo_wr1     (fifo_wr1),
    .fifo_wr2     (fifo_wr2)
  );

  always_comb begin
    free     = DEPTH - cnt_q;
    empty    = (cnt_q == '0);
    rd_valid = ~empty;
    ge2_free = (free >= CW'(2));
    ge3_free = (free >= CW'(3));
    pop      = rd_valid & rd_ready;

    // Admission uses pre-pop free space, so the sum can never exceed DEPTH
    cnt_d      = cnt_q + CW'(n_wr) - CW'(pop);
    wrptr_d    = wrptr_q + DEPTH_LOG2'(n_wr);
    rdptr_d    = rdptr_q + DEPTH_LOG2'(pop);
    overflow_d = (dropped != 2'd0) ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      wrptr_q    <= '0;
      rdptr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrptr_q    <= wrptr_d;
      rdptr_q    <= rdptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign fifo_cnt   = cnt_q;
  assign fifo_wrptr = wrptr_q;
  assign fifo_rdptr = rdptr_q;
  assign overflow   = overflow_q;

`ifdef MI_NIOS_OCI_FIFO_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'(dropped);
    if (ovf_clr) begin
      drop_cnt_d = DROP_CNT_W'(dropped);
    end else begin
      drop_cnt_d = drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mi_nios_cpu_nios2_oci_fifo_wr_ctrl.sv
// ============================================================================
// tb_mi_nios_cpu_nios2_oci_fifo_wr_ctrl : directed self-checking bench
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mi_nios_cpu_nios2_oci_fifo_wr_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  input_tm_cnt;
  logic        rd_ready;
  logic        ovf_clr;
  logic [3:0]  fifo_wrptr;
  logic        fifo_wr0, fifo_wr1, fifo_wr2;
  logic [3:0]  fifo_rdptr;
  logic        rd_valid;
  logic [4:0]  fifo_cnt;
  logic        empty, ge2_free, ge3_free, overflow;
`ifdef MI_NIOS_OCI_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mi_nios_cpu_nios2_oci_fifo_wr_ctrl #(.DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_tm_cnt (input_tm_cnt),
    .rd_ready     (rd_ready),
    .ovf_clr      (ovf_clr),
    .fifo_wrptr   (fifo_wrptr),
    .fifo_wr0     (fifo_wr0),
    .fifo_wr1     (fifo_wr1),
    .fifo_wr2     (fifo_wr2),
    .fifo_rdptr   (fifo_rdptr),
    .rd_valid     (rd_valid),
    .fifo_cnt     (fifo_cnt),
    .empty        (empty),
    .ge2_free     (ge2_free),
    .ge3_free     (ge3_free),
    .overflow     (overflow)
`ifdef MI_NIOS_OCI_FIFO_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_drop(input string tag, input logic [31:0] exp);
`ifdef MI_NIOS_OCI_FIFO_DROP_CNT_EN
    chk(tag, {16'h0, drop_cnt}, exp);
`else
    if (exp === 32'hFFFF_FFFF) $display("unused %s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tm, input logic rr, input logic clr);
    input_tm_cnt = tm;
    rd_ready     = rr;
    ovf_clr      = clr;
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input int wp, input int rp, input logic ovf);
    chk({tag, "_cnt"},   {27'h0, fifo_cnt}, cnt);
    chk({tag, "_wrptr"}, {28'h0, fifo_wrptr}, wp);
    chk({tag, "_rdptr"}, {28'h0, fifo_rdptr}, rp);
    chk({tag, "_ovf"},   {31'h0, overflow}, {31'h0, ovf});
  endtask

  task automatic chk_wr(input string tag, input logic [2:0] en);
    chk({tag, "_wren"}, {29'h0, fifo_wr2, fifo_wr1, fifo_wr0}, {29'h0, en});
  endtask

  initial begin
    reset = 1'b1;
    drive(2'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk_state("rst", 0, 0, 0, 1'b0);
    chk("rst_empty", {31'h0, empty}, 1);
    chk("rst_rdvalid", {31'h0, rd_valid}, 0);
    chk("rst_ge2", {31'h0, ge2_free}, 1);
    chk("rst_ge3", {31'h0, ge3_free}, 1);
    chk_drop("rst_drop", 0);

    // Five bursts of three words, no consumer
    for (int i = 1; i <= 5; i++) begin
      drive(2'd3, 1'b0, 1'b0);
      chk_wr("fill", 3'b111);
      tick();
      chk_state("fill", 3 * i, (3 * i) % 16, 0, 1'b0);
    end
    chk("fill15_ge2", {31'h0, ge2_free}, 0);
    chk("fill15_ge3", {31'h0, ge3_free}, 0);

    // One pop, nothing offered -> cnt 14, wrptr still 15
    drive(2'd0, 1'b1, 1'b0);
    chk_wr("pop1", 3'b000);
    tick();
    chk_state("pop1", 14, 15, 1, 1'b0);
    chk("cnt14_ge2", {31'h0, ge2_free}, 1);
    chk("cnt14_ge3", {31'h0, ge3_free}, 0);

    // Wrap: slots at 15 and 0 written, slot 2 dropped
    drive(2'd3, 1'b0, 1'b0);
    chk_wr("wrap", 3'b011);
    chk("wrap_addr", {28'h0, fifo_wrptr}, 15);
    tick();
    chk_state("wrap", 16, 1, 1, 1'b1);
    chk_drop("wrap_drop", 1);

    // Full with a pop: no writes, both words dropped
    drive(2'd2, 1'b1, 1'b0);
    chk_wr("fullpop", 3'b000);
    chk("fullpop_rdvalid", {31'h0, rd_valid}, 1);
    tick();
    chk_state("fullpop", 15, 1, 2, 1'b1);
    chk_drop("fullpop_drop", 3);

    // Clear coinciding with a drop: overflow held, drop counter restarts
    drive(2'd3, 1'b0, 1'b1);
    chk_wr("clrdrop", 3'b001);
    tick();
    chk_state("clrdrop", 16, 2, 2, 1'b1);
    chk_drop("clrdrop_drop", 2);

    // Drain to nine words
    for (int i = 0; i < 7; i++) begin
      drive(2'd0, 1'b1, 1'b0);
      tick();
    end
    chk_state("drain", 9, 2, 9, 1'b1);

    // Reset during mixed traffic
    reset = 1'b1;
    drive(2'd3, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    drive(2'd0, 1'b0, 1'b0);
    chk_state("midrst", 0, 0, 0, 1'b0);
    chk("midrst_empty", {31'h0, empty}, 1);
    chk_drop("midrst_drop", 0);

    // Fill to 15, then a sixth burst admits only slot 0
    for (int i = 0; i < 5; i++) begin
      drive(2'd3, 1'b0, 1'b0);
      tick();
    end
    drive(2'd3, 1'b0, 1'b0);
    chk_wr("sixth", 3'b001);
    tick();
    chk_state("sixth", 16, 0, 0, 1'b1);
    chk_drop("sixth_drop", 2);

    // Clear with no drop
    drive(2'd0, 1'b0, 1'b1);
    tick();
    chk_state("clr", 16, 0, 0, 1'b0);
    chk_drop("clr_drop", 0);

    // Empty FIFO: write and pop request together, no bypass
    reset = 1'b1;
    drive(2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(2'd1, 1'b1, 1'b0);
    chk("byp_rdvalid0", {31'h0, rd_valid}, 0);
    chk_wr("byp", 3'b001);
    tick();
    chk_state("byp", 1, 1, 0, 1'b0);
    chk("byp_rdvalid1", {31'h0, rd_valid}, 1);
    drive(2'd0, 1'b1, 1'b0);
    tick();
    chk_state("bypop", 0, 1, 1, 1'b0);
    chk("bypop_empty", {31'h0, empty}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
